// File: rtl/f_pc_unit.sv
// f_pc_unit: fetch-stage program counter with stall hold, redirect buffering and optional exception vectoring
// Optional feature macro: PC_EXC_EN (exception redirect to EXC_VECTOR plus fetch-address checking on adel).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall           freeze pc; a redirect arriving meanwhile is buffered
//   redir_valid     taken branch/jump, redir_target is the new fetch address
//   exc_req         jump to EXC_VECTOR, overriding stall and redirects (PC_EXC_EN only)
//   pc, pc4, pc8    current fetch address and its sequential/link successors
//   redir_pending   a buffered redirect waits for the stall to clear
//   adel            current pc is misaligned or outside the fetch window (PC_EXC_EN only)
module f_pc_unit #(
  parameter int               WIDTH      = 32,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IMEM_BASE  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IMEM_SIZE  = 32'h0000_4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] pc8,
  output logic             redir_pending,
  output logic             adel
);
`ifdef PC_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] STEP1 = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] STEP2 = WIDTH'(2 * STEP);
  // one extra bit so a window ending exactly at 2^WIDTH does not wrap to zero
  localparam logic [WIDTH:0]   LIMIT = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] tgt_q;
  logic             exc;
  logic             bad_addr;
  assign exc      = EXC_EN & exc_req;
  assign bad_addr = (pc_q[1:0] != 2'b00) | (pc_q < IMEM_BASE) | ({1'b0, pc_q} >= LIMIT);
  assign pc            = pc_q;
  assign pc4           = pc_q + STEP1;
  assign pc8           = pc_q + STEP2;
  assign redir_pending = (state_q == HOLD);
  assign adel          = EXC_EN & bad_addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      tgt_q   <= '0;
    end else if (exc) begin
      pc_q    <= EXC_VECTOR;
      state_q <= RUN;
    end else if (stall) begin
      if (redir_valid) begin
        state_q <= HOLD;
        tgt_q   <= redir_target;
      end
    end else if (redir_valid) begin
      pc_q    <= redir_target;
      state_q <= RUN;
    end else if (state_q == HOLD) begin
      pc_q    <= tgt_q;
      state_q <= RUN;
    end else begin
      pc_q    <= pc4;
    end
  end
endmodule

// File: tb/tb_f_pc_unit.sv
// tb_f_pc_unit: directed vector table plus randomized run against a reference model of f_pc_unit
module tb_f_pc_unit;
`ifdef PC_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, exc_req;
  logic [31:0] redir_target;
  logic [31:0] pc, pc4, pc8;
  logic        redir_pending, adel;
  int checks = 0;
  int errors = 0;

  f_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .exc_req(exc_req), .pc(pc), .pc4(pc4),
    .pc8(pc8), .redir_pending(redir_pending), .adel(adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r, s, rv;
    logic [31:0] t;
    logic        e;
    logic [31:0] pc;
    logic        pend;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_adel(logic [31:0] p);
    return EXC_ON && ((p % 4) != 0 || p < 32'h3000 || p >= 32'h7000);
  endfunction

  task automatic check_out(string tag, logic [31:0] p, logic pend);
    chk({tag, " pc"}, pc, p);
    chk({tag, " pc4"}, pc4, p + 32'd4);
    chk({tag, " pc8"}, pc8, p + 32'd8);
    chk({tag, " pending"}, {31'b0, redir_pending}, {31'b0, pend});
    chk({tag, " adel"}, {31'b0, adel}, {31'b0, exp_adel(p)});
  endtask

  task automatic drive(logic r, logic s, logic rv, logic [31:0] t, logic e);
    @(negedge clk);
    reset = r; stall = s; redir_valid = rv; redir_target = t; exc_req = e;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(string n, logic r, logic s, logic rv, logic [31:0] t,
                              logic e, logic [31:0] p, logic pend);
    vec_t v;
    v.name = n; v.r = r; v.s = s; v.rv = rv; v.t = t; v.e = e; v.pc = p; v.pend = pend;
    vecs.push_back(v);
  endfunction

  logic [31:0] mpc;
  logic [31:0] mq[$];

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = '0; exc_req = 1'b0;
    add("rst0",      1, 0, 0, 0,            0, 32'h3000, 0);
    add("rst1",      1, 0, 0, 0,            0, 32'h3000, 0);
    add("seq1",      0, 0, 0, 0,            0, 32'h3004, 0);
    add("seq2",      0, 0, 0, 0,            0, 32'h3008, 0);
    add("seq3",      0, 0, 0, 0,            0, 32'h300C, 0);
    add("redir",     0, 0, 1, 32'h3100,     0, 32'h3100, 0);
    add("redir+1",   0, 0, 0, 0,            0, 32'h3104, 0);
    add("stall_r1",  0, 1, 1, 32'h3200,     0, 32'h3104, 1);
    add("stall_r2",  0, 1, 1, 32'h3300,     0, 32'h3104, 1);
    add("stall3",    0, 1, 0, 0,            0, 32'h3104, 1);
    add("release",   0, 0, 0, 0,            0, 32'h3300, 0);
    add("hold",      0, 1, 1, 32'h3200,     0, 32'h3300, 1);
    add("live_ovr",  0, 0, 1, 32'h3400,     0, 32'h3400, 0);
    add("dropped",   0, 0, 0, 0,            0, 32'h3404, 0);
    add("wrap_tgt",  0, 0, 1, 32'hFFFF_FFFC,0, 32'hFFFF_FFFC, 0);
    add("wrap",      0, 0, 0, 0,            0, 32'h0000_0000, 0);
    add("rst2",      1, 0, 0, 0,            0, 32'h3000, 0);
    add("s1",        0, 0, 0, 0,            0, 32'h3004, 0);
    add("s2",        0, 0, 0, 0,            0, 32'h3008, 0);
    add("s3",        0, 0, 0, 0,            0, 32'h300C, 0);
    add("s4",        0, 0, 0, 0,            0, 32'h3010, 0);
    add("hold3500",  0, 1, 1, 32'h3500,     0, 32'h3010, 1);
    add("rst_hold",  1, 1, 0, 0,            0, 32'h3000, 0);
    add("after_rst", 0, 0, 0, 0,            0, 32'h3004, 0);
`ifdef PC_EXC_EN
    add("exc",       0, 0, 0, 0,            1, 32'h4180, 0);
    add("hold_e",    0, 1, 1, 32'h3200,     0, 32'h4180, 1);
    add("exc_hold",  0, 1, 1, 32'h3600,     1, 32'h4180, 0);
    add("misalign",  0, 0, 1, 32'h3002,     0, 32'h3002, 0);
    add("beyond",    0, 0, 1, 32'h7000,     0, 32'h7000, 0);
    add("legal",     0, 0, 1, 32'h3004,     0, 32'h3004, 0);
    add("below",     0, 0, 1, 32'h2FFC,     0, 32'h2FFC, 0);
    add("top",       0, 0, 1, 32'h6FFC,     0, 32'h6FFC, 0);
`else
    add("exc_ign",   0, 0, 0, 0,            1, 32'h3008, 0);
    add("hold_e",    0, 1, 1, 32'h3200,     0, 32'h3008, 1);
    add("exc_hold",  0, 1, 0, 0,            1, 32'h3008, 1);
    add("exc_rel",   0, 0, 0, 0,            1, 32'h3200, 0);
`endif
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].rv, vecs[i].t, vecs[i].e);
      check_out(vecs[i].name, vecs[i].pc, vecs[i].pend);
    end

    // randomized run: model keeps the newest buffered target in a one-slot queue
    for (int n = 0; n < 600; n++) begin
      logic r, s, rv, e;
      logic [31:0] t;
      r  = (n == 0) || ($urandom_range(31) == 0);
      s  = ($urandom_range(2) == 0);
      rv = ($urandom_range(2) == 0);
      e  = ($urandom_range(7) == 0);
      t  = ($urandom_range(3) == 0) ? 32'($urandom) : 32'h3000 + 32'($urandom_range(16'h4100)) ;
      drive(r, s, rv, t, e);
      if (r) begin
        mpc = 32'h3000; mq.delete();
      end else if (EXC_ON && e) begin
        mpc = 32'h4180; mq.delete();
      end else if (s) begin
        if (rv) begin
          mq.delete(); mq.push_back(t);
        end
      end else if (rv) begin
        mpc = t; mq.delete();
      end else if (mq.size() != 0) begin
        mpc = mq.pop_front();
      end else begin
        mpc = mpc + 32'd4;
      end
      check_out("rand", mpc, mq.size() != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Parametrised fetch-stage program-counter unit for the pipelined MIPS core. It replaces the bare PC+4 incrementer with a registered PC that supports stall hold, branch/jump redirect, and redirect buffering across stalls. It also provides precomputed sequential/link addresses and, optionally, exception vectoring with instruction-address checking. It sits at the head of the F stage, feeding IM and the F/D pipeline register.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- STEP, 4, byte increment per instruction
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, exception entry address (used only with PC_EXC_EN)
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address (PC_EXC_EN only)
- IMEM_SIZE, 32'h0000_4000, legal fetch window size in bytes (PC_EXC_EN only)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  freeze PC (from hazard unit)
- redir_valid  input  1  taken branch/jump this cycle
- redir_target  input  WIDTH  redirect address
- exc_req  input  1  take exception (ignored without PC_EXC_EN)
- pc  output  WIDTH  current fetch address
- pc4  output  WIDTH  pc + STEP
- pc8  output  WIDTH  pc + 2*STEP (link address)
- redir_pending  output  1  a redirect is buffered, awaiting stall release
- adel  output  1  fetch address exception for current pc (0 without PC_EXC_EN)

## Operation
- State: pc register (WIDTH), pend_valid (1), pend_target (WIDTH). Two-state FSM encoded by pend_valid: RUN (0), HOLD (1).
- Update priority per edge, highest first: reset > exc_req > stall > live redirect > buffered redirect > sequential.
- reset=1: pc <= RESET_PC, pend_valid <= 0, pend_target <= 0.
- exc_req=1 (macro on): pc <= EXC_VECTOR, pend_valid <= 0; overrides stall and any redirect.
- stall=1: pc holds. If redir_valid=1: pend_target <= redir_target, pend_valid <= 1 (RUN->HOLD, or HOLD->HOLD with newest target overwriting).
- stall=0, redir_valid=1: pc <= redir_target, pend_valid <= 0 (a live redirect supersedes a buffered one).
- stall=0, redir_valid=0, pend_valid=1: pc <= pend_target, pend_valid <= 0 (HOLD->RUN).
- Otherwise: pc <= pc + STEP.
- Arithmetic is modulo 2^WIDTH; carry out is discarded. pc4/pc8 wrap identically.
- redir_pending = pend_valid.

## Timing
- pc, redir_pending: registered. After reset, pc=RESET_PC, pc4=RESET_PC+STEP, pc8=RESET_PC+2*STEP, redir_pending=0, adel=0 for the default parameters.
- pc4, pc8, adel: combinational from pc, same cycle.
- Redirect latency: 1 cycle (visible on pc in the cycle after redir_valid with stall=0). A buffered redirect appears on pc 1 cycle after stall deasserts.
- Exception latency: 1 cycle, regardless of stall.
- Reset mid-HOLD: buffered redirect is discarded.

## Configuration
- PC_EXC_EN defined: exc_req is honoured as above. adel = (pc[1:0] != 0) | (pc < IMEM_BASE) | (pc >= IMEM_BASE + IMEM_SIZE), combinational. The PC still advances normally when adel=1; the exception unit decides.
- PC_EXC_EN undefined: exc_req is ignored, adel is tied to 0, and the EXC_VECTOR/IMEM_* parameters are unused.

## Test plan
- Reset held 2 cycles, then released -> pc=0x3000, pc4=0x3004, pc8=0x3008; after 3 free cycles pc=0x300C.
- redir_valid=1, target=0x3100, stall=0 -> next cycle pc=0x3100; following cycle pc=0x3104.
- stall=1 for 3 cycles, redir 0x3200 in stall cycle 1 and 0x3300 in stall cycle 2 -> pc frozen, redir_pending=1; first cycle after release pc=0x3300, redir_pending=0.
- HOLD with pend_target=0x3200, then stall=0 with live redir 0x3400 -> pc=0x3400, buffered target dropped. Redirect to 0xFFFF_FFFC -> next pc=0x0000_0000.
- PC_EXC_EN: exc_req=1 with stall=1 and redir_pending=1 -> pc=0x4180, redir_pending=0. Redirect to 0x3002 -> adel=1. Redirect to 0x7000 -> adel=1. Redirect to 0x3004 -> adel=0.
- reset=1 during HOLD (pc=0x3010, pending 0x3500) -> pc=0x3000, redir_pending=0. Without PC_EXC_EN, exc_req=1 -> pc advances by 4, adel=0.
